// File: rtl/mem_access_unit.sv
// Load/store front end between EX/MEM and word-wide Data_mem.
// Sub-word stores run as a two-cycle read-modify-write.
module mem_access_unit #(
  parameter int MEM_DEPTH   = 256,
  parameter bit RANGE_CHECK = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_write,
  output logic        mem_read,
  input  logic [31:0] mem_rdata
);

  typedef enum logic {
    IDLE,
    MERGE
  } state_t;

  state_t      state_q, state_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic        rsp_err_q, rsp_err_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;
  logic [31:0] mrg_addr_q, mrg_addr_d;
  logic [31:0] mrg_data_q, mrg_data_d;

  logic [31:0] idx;
  logic [4:0]  sh_amt;
  logic [15:0] lane;
  logic [31:0] ld_data;
  logic [31:0] wmask;
  logic [31:0] merged;
  logic        misal;
  logic        bad_size;
  logic        oor;
  logic        err;
  logic        accept;
  logic        sub_st;

  assign req_ready = (state_q == IDLE) && !rst;
  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_rdata = rsp_rdata_q;

  always_comb begin
    idx      = {2'b00, req_addr[31:2]};
    sh_amt   = {req_addr[1:0], 3'b000};
    lane     = 16'(mem_rdata >> sh_amt);
    bad_size = (req_size == 2'b11);
    misal    = ((req_size == 2'b01) && req_addr[0])
            || ((req_size == 2'b10) && (req_addr[1:0] != 2'b00));
    oor      = RANGE_CHECK && (idx >= 32'(MEM_DEPTH));
    err      = bad_size || misal || oor;
    accept   = req_valid && req_ready;
    sub_st   = req_write && !req_size[1];

    ld_data = mem_rdata;
    wmask   = 32'hFFFF_FFFF;
    unique case (1'b1)
      (req_size == 2'b00): begin
        ld_data = req_unsigned ? {24'h0, lane[7:0]}
                               : {{24{lane[7]}}, lane[7:0]};
        wmask   = 32'h0000_00FF;
      end
      (req_size == 2'b01): begin
        ld_data = req_unsigned ? {16'h0, lane}
                               : {{16{lane[15]}}, lane};
        wmask   = 32'h0000_FFFF;
      end
      default: ;
    endcase

    // Target lane replaced, other lanes kept from the current word
    merged = (mem_rdata & ~(wmask << sh_amt))
           | ((req_wdata & wmask) << sh_amt);
  end

  always_comb begin
    state_d     = state_q;
    mrg_addr_d  = mrg_addr_q;
    mrg_data_d  = mrg_data_q;
    rsp_valid_d = 1'b0;
    rsp_err_d   = 1'b0;
    rsp_rdata_d = 32'h0;
    mem_addr    = 32'h0;
    mem_wdata   = 32'h0;
    mem_write   = 1'b0;
    mem_read    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          if (err) begin
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
          end else if (!req_write) begin
            mem_read    = 1'b1;
            mem_addr    = idx;
            rsp_valid_d = 1'b1;
            rsp_rdata_d = ld_data;
          end else if (!sub_st) begin
            mem_write   = 1'b1;
            mem_addr    = idx;
            mem_wdata   = req_wdata;
            rsp_valid_d = 1'b1;
          end else begin
            mem_read   = 1'b1;
            mem_addr   = idx;
            mrg_addr_d = idx;
            mrg_data_d = merged;
            state_d    = MERGE;
          end
        end
      end
      MERGE: begin
        state_d = IDLE;
        // Reset during MERGE drops the pending write
        if (!rst) begin
          mem_write   = 1'b1;
          mem_addr    = mrg_addr_q;
          mem_wdata   = mrg_data_q;
          rsp_valid_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= 32'h0;
      mrg_addr_q  <= 32'h0;
      mrg_data_q  <= 32'h0;
    end else begin
      state_q     <= state_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
      mrg_addr_q  <= mrg_addr_d;
      mrg_data_q  <= mrg_data_d;
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: word-wide memory model plus response scoreboard.
// A second instance with the range check disabled covers the unbounded case.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_write;
  logic        mem_read;
  logic [31:0] mem_rdata;

  logic        nr_req_ready;
  logic        nr_rsp_valid;
  logic [31:0] nr_rsp_rdata;
  logic        nr_rsp_err;
  logic [31:0] nr_mem_addr;
  logic [31:0] nr_mem_wdata;
  logic        nr_mem_write;
  logic        nr_mem_read;
  logic [31:0] nr_mem_rdata;

  logic [31:0] mem [256];

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t sb_q[$];
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  mem_access_unit #(.MEM_DEPTH(256), .RANGE_CHECK(1'b1)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_size(req_size),
    .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_write(mem_write), .mem_read(mem_read),
    .mem_rdata(mem_rdata)
  );

  mem_access_unit #(.MEM_DEPTH(256), .RANGE_CHECK(1'b0)) dut_nr (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(nr_req_ready),
    .req_write(req_write), .req_size(req_size),
    .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata),
    .rsp_valid(nr_rsp_valid), .rsp_rdata(nr_rsp_rdata),
    .rsp_err(nr_rsp_err),
    .mem_addr(nr_mem_addr), .mem_wdata(nr_mem_wdata),
    .mem_write(nr_mem_write), .mem_read(nr_mem_read),
    .mem_rdata(nr_mem_rdata)
  );

  assign mem_rdata    = mem[mem_addr[7:0]];
  assign nr_mem_rdata = 32'h5A5A_5A5A;

  always @(posedge clk) begin
    if (mem_write === 1'b1) mem[mem_addr[7:0]] = mem_wdata;
  end

  always @(negedge clk) begin
    if (rsp_valid === 1'b1) begin
      exp_t e;
      total++;
      if (sb_q.size() == 0) begin
        bad++;
        $display("FAIL sb_unexpected got rdata=%h err=%b exp=none",
                 rsp_rdata, rsp_err);
      end else begin
        e = sb_q.pop_front();
        if (rsp_rdata !== e.rdata || rsp_err !== e.err) begin
          bad++;
          $display("FAIL sb_rsp got rdata=%h err=%b exp rdata=%h err=%b",
                   rsp_rdata, rsp_err, e.rdata, e.err);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic w, input logic [1:0] sz,
                       input logic u, input logic [31:0] a,
                       input logic [31:0] d);
    req_valid    = 1'b1;
    req_write    = w;
    req_size     = sz;
    req_unsigned = u;
    req_addr     = a;
    req_wdata    = d;
  endtask

  task automatic idle();
    req_valid = 1'b0;
    req_write = 1'b0;
    req_size  = 2'b10;
    req_addr  = 32'h0;
    req_wdata = 32'h0;
  endtask

  task automatic push(input logic [31:0] d, input logic e);
    exp_t x;
    x.rdata = d;
    x.err   = e;
    sb_q.push_back(x);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle();
    req_unsigned = 1'b0;
    step();
    step();
    total++;
    if (req_ready !== 1'b0) begin
      bad++;
      $display("FAIL rst_ready got=%b exp=0", req_ready);
    end
    rst = 1'b0;
    #1;
    total++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0 ||
        rsp_err !== 1'b0 || rsp_rdata !== 32'h0) begin
      bad++;
      $display("FAIL rst_state got rdy=%b v=%b e=%b d=%h exp 1 0 0 0",
               req_ready, rsp_valid, rsp_err, rsp_rdata);
    end
  endtask

  task automatic test_idle();
    step();
    idle();
    req_addr = 32'h0000_0044;
    #1;
    total++;
    if (mem_read !== 1'b0 || mem_write !== 1'b0 ||
        mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin
      bad++;
      $display("FAIL idle_mem got r=%b w=%b a=%h d=%h exp all 0",
               mem_read, mem_write, mem_addr, mem_wdata);
    end
    step();
    total++;
    if (rsp_valid !== 1'b0) begin
      bad++;
      $display("FAIL idle_rsp got=%b exp=0", rsp_valid);
    end
  endtask

  task automatic test_back_to_back();
    step();
    drive(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEAD_BEEF);
    push(32'h0, 1'b0);
    #1;
    total++;
    if (mem_write !== 1'b1 || mem_read !== 1'b0 ||
        mem_addr !== 32'd4 || mem_wdata !== 32'hDEAD_BEEF) begin
      bad++;
      $display("FAIL sw_mem got w=%b r=%b a=%h d=%h exp 1 0 4 deadbeef",
               mem_write, mem_read, mem_addr, mem_wdata);
    end
    step();
    drive(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
    push(32'hDEAD_BEEF, 1'b0);
    #1;
    total++;
    if (mem_read !== 1'b1 || mem_write !== 1'b0 ||
        mem_addr !== 32'd4 || req_ready !== 1'b1) begin
      bad++;
      $display("FAIL lw_mem got r=%b w=%b a=%h rdy=%b exp 1 0 4 1",
               mem_read, mem_write, mem_addr, req_ready);
    end
    step();
    idle();
  endtask

  task automatic test_sub_store();
    mem[3] = 32'h1122_3344;
    step();
    drive(1'b1, 2'b00, 1'b0, 32'h0D, 32'h0000_00A5);
    push(32'h0, 1'b0);
    #1;
    total++;
    if (req_ready !== 1'b1 || mem_read !== 1'b1 ||
        mem_write !== 1'b0 || mem_addr !== 32'd3) begin
      bad++;
      $display("FAIL sb_c0 got rdy=%b r=%b w=%b a=%h exp 1 1 0 3",
               req_ready, mem_read, mem_write, mem_addr);
    end
    step();
    idle();
    #1;
    total++;
    if (req_ready !== 1'b0 || mem_write !== 1'b1 || mem_read !== 1'b0 ||
        mem_addr !== 32'd3 || mem_wdata !== 32'h1122_A544 ||
        rsp_valid !== 1'b0) begin
      bad++;
      $display("FAIL sb_merge got rdy=%b w=%b r=%b a=%h d=%h v=%b",
               req_ready, mem_write, mem_read, mem_addr, mem_wdata,
               rsp_valid);
    end
    step();
    total++;
    if (rsp_valid !== 1'b1 || req_ready !== 1'b1 ||
        mem[3] !== 32'h1122_A544) begin
      bad++;
      $display("FAIL sb_c2 got v=%b rdy=%b word=%h exp 1 1 1122a544",
               rsp_valid, req_ready, mem[3]);
    end
    mem[5] = 32'hFFFF_FFFF;
    drive(1'b1, 2'b01, 1'b0, 32'h16, 32'hAAAA_1234);
    push(32'h0, 1'b0);
    step();
    idle();
    step();
    total++;
    if (mem[5] !== 32'h1234_FFFF) begin
      bad++;
      $display("FAIL sh_word got=%h exp=1234ffff", mem[5]);
    end
  endtask

  task automatic test_sub_load();
    mem[3] = 32'h12F0_0000;
    step();
    drive(1'b0, 2'b00, 1'b0, 32'h0E, 32'h0);
    push(32'hFFFF_FFF0, 1'b0);
    step();
    drive(1'b0, 2'b00, 1'b1, 32'h0E, 32'h0);
    push(32'h0000_00F0, 1'b0);
    step();
    drive(1'b0, 2'b01, 1'b0, 32'h0E, 32'h0);
    push(32'h0000_12F0, 1'b0);
    step();
    mem[6] = 32'h0000_8001;
    drive(1'b0, 2'b01, 1'b0, 32'h18, 32'h0);
    push(32'hFFFF_8001, 1'b0);
    step();
    drive(1'b0, 2'b01, 1'b1, 32'h18, 32'h0);
    push(32'h0000_8001, 1'b0);
    step();
    idle();
  endtask

  task automatic test_errors();
    logic [1:0]  sz [4] = '{2'b01, 2'b10, 2'b11, 2'b01};
    logic [31:0] ad [4] = '{32'h05, 32'h06, 32'h10, 32'h23};
    logic        wr [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 4; i++) begin
      step();
      drive(wr[i], sz[i], 1'b0, ad[i], 32'hFFFF_FFFF);
      push(32'h0, 1'b1);
      #1;
      total++;
      if (mem_read !== 1'b0 || mem_write !== 1'b0 || req_ready !== 1'b1) begin
        bad++;
        $display("FAIL err_mem%0d got r=%b w=%b rdy=%b exp 0 0 1",
                 i, mem_read, mem_write, req_ready);
      end
    end
    step();
    idle();
  endtask

  task automatic test_range();
    mem[255] = 32'hC0DE_0FF5;
    step();
    drive(1'b0, 2'b10, 1'b0, 32'h3FC, 32'h0);
    push(32'hC0DE_0FF5, 1'b0);
    step();
    drive(1'b0, 2'b10, 1'b0, 32'h400, 32'h0);
    push(32'h0, 1'b1);
    #1;
    total++;
    if (mem_read !== 1'b0 || nr_mem_read !== 1'b1 ||
        nr_mem_addr !== 32'h100) begin
      bad++;
      $display("FAIL range_mem got r=%b nr_r=%b nr_a=%h exp 0 1 100",
               mem_read, nr_mem_read, nr_mem_addr);
    end
    step();
    idle();
    total++;
    if (nr_rsp_valid !== 1'b1 || nr_rsp_err !== 1'b0 ||
        nr_rsp_rdata !== 32'h5A5A_5A5A) begin
      bad++;
      $display("FAIL range_off got v=%b e=%b d=%h exp 1 0 5a5a5a5a",
               nr_rsp_valid, nr_rsp_err, nr_rsp_rdata);
    end
  endtask

  task automatic test_merge_reset();
    mem[2] = 32'hCAFE_F00D;
    step();
    drive(1'b1, 2'b01, 1'b0, 32'h0A, 32'h0000_BEEF);
    #1;
    total++;
    if (mem_read !== 1'b1) begin
      bad++;
      $display("FAIL mrst_c0 got r=%b exp=1", mem_read);
    end
    step();
    idle();
    rst = 1'b1;
    #1;
    total++;
    if (mem_write !== 1'b0 || req_ready !== 1'b0) begin
      bad++;
      $display("FAIL mrst_drop got w=%b rdy=%b exp 0 0",
               mem_write, req_ready);
    end
    step();
    rst = 1'b0;
    #1;
    total++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || rsp_err !== 1'b0 ||
        rsp_rdata !== 32'h0 || mem[2] !== 32'hCAFE_F00D) begin
      bad++;
      $display("FAIL mrst_after got rdy=%b v=%b e=%b d=%h w2=%h",
               req_ready, rsp_valid, rsp_err, rsp_rdata, mem[2]);
    end
    step();
    total++;
    if (rsp_valid !== 1'b0 || mem_write !== 1'b0) begin
      bad++;
      $display("FAIL mrst_late got v=%b w=%b exp 0 0",
               rsp_valid, mem_write);
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    test_reset();
    test_idle();
    test_back_to_back();
    test_sub_store();
    test_sub_load();
    test_errors();
    test_range();
    test_merge_reset();
    repeat (4) step();
    total++;
    if (sb_q.size() != 0) begin
      bad++;
      $display("FAIL sb_drain got=%0d pending exp=0", sb_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
